// File: rtl/id_stage_pkg.sv
// Shared decode vocabulary: ALU op codes, RV32I opcodes, immediate kinds and
// the decoded micro-op bundle carried through the id_stage skid buffer.
package id_stage_pkg;

    localparam logic [4:0] IADD = 5'd0;
    localparam logic [4:0] ISUB = 5'd1;
    localparam logic [4:0] IAND = 5'd2;
    localparam logic [4:0] IOR  = 5'd3;
    localparam logic [4:0] IXOR = 5'd4;
    localparam logic [4:0] IPAS = 5'd5;
    localparam logic [4:0] IEQ  = 5'd6;
    localparam logic [4:0] INE  = 5'd7;
    localparam logic [4:0] ILT  = 5'd8;
    localparam logic [4:0] IGE  = 5'd9;
    localparam logic [4:0] ILTU = 5'd10;
    localparam logic [4:0] IGEU = 5'd11;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_SH
    } imm_kind_e;

    // imm is kept at 32 bits; it is already sign-extended from instr[31],
    // so widening to XLEN is a plain signed extension.
    typedef struct packed {
        logic [4:0]  alu_op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        a_sel;
        logic        b_sel;
        logic        rd_we;
        logic        is_branch;
        logic        is_jump;
        logic        is_load;
        logic        is_store;
        logic        is_shift;
        logic [2:0]  funct3;
        logic        illegal;
    } decoded_t;

    function automatic logic [31:0] build_imm(input imm_kind_e kind, input logic [31:0] i);
        logic [31:0] r;
        case (kind)
            IMM_I:   r = {{20{i[31]}}, i[31:20]};
            IMM_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   r = {i[31:12], 12'b0};
            IMM_J:   r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            IMM_SH:  r = {27'b0, i[24:20]};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch-side and execute-side valid/ready streams of the decode stage.
interface id_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_instr;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_alu_op;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic            out_a_sel;
    logic            out_b_sel;
    logic            out_rd_we;
    logic            out_is_branch;
    logic            out_is_jump;
    logic            out_is_load;
    logic            out_is_store;
    logic            out_is_shift;
    logic [2:0]      out_funct3;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_alu_op, out_rs1, out_rs2, out_rd,
               out_imm, out_a_sel, out_b_sel, out_rd_we, out_is_branch, out_is_jump,
               out_is_load, out_is_store, out_is_shift, out_funct3, out_illegal
    );

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_alu_op, out_rs1, out_rs2, out_rd,
               out_imm, out_a_sel, out_b_sel, out_rd_we, out_is_branch, out_is_jump,
               out_is_load, out_is_store, out_is_shift, out_funct3, out_illegal
    );
endinterface

// File: rtl/id_stage_decode.sv
// Purely combinational RV32I instruction word to micro-op bundle decoder.
module id_decode
    import id_stage_pkg::*;
(
    input  logic [31:0] instr,
    output decoded_t    dec
);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       legal;
    logic       we;
    imm_kind_e  kind;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];

    always_comb begin
        dec        = '0;
        kind       = IMM_NONE;
        legal      = 1'b1;
        we         = 1'b0;
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.rd     = instr[11:7];
        dec.funct3 = f3;
        dec.alu_op = IADD;

        case (opc)
            OPC_LUI: begin
                dec.alu_op = IPAS;
                dec.b_sel  = 1'b1;
                kind       = IMM_U;
                we         = 1'b1;
            end
            OPC_AUIPC: begin
                dec.a_sel = 1'b1;
                dec.b_sel = 1'b1;
                kind      = IMM_U;
                we        = 1'b1;
            end
            OPC_JAL: begin
                dec.a_sel   = 1'b1;
                dec.b_sel   = 1'b1;
                dec.is_jump = 1'b1;
                kind        = IMM_J;
                we          = 1'b1;
            end
            OPC_JALR: begin
                dec.b_sel   = 1'b1;
                dec.is_jump = 1'b1;
                kind        = IMM_I;
                we          = 1'b1;
            end
            OPC_BRANCH: begin
                dec.is_branch = 1'b1;
                kind          = IMM_B;
                case (f3)
                    3'b000:  dec.alu_op = IEQ;
                    3'b001:  dec.alu_op = INE;
                    3'b100:  dec.alu_op = ILT;
                    3'b101:  dec.alu_op = IGE;
                    3'b110:  dec.alu_op = ILTU;
                    3'b111:  dec.alu_op = IGEU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                dec.b_sel   = 1'b1;
                dec.is_load = 1'b1;
                kind        = IMM_I;
                we          = 1'b1;
            end
            OPC_STORE: begin
                dec.b_sel    = 1'b1;
                dec.is_store = 1'b1;
                kind         = IMM_S;
            end
            OPC_OPIMM: begin
                dec.b_sel = 1'b1;
                kind      = IMM_I;
                we        = 1'b1;
                case (f3)
                    3'b000: dec.alu_op = IADD;
                    3'b010: dec.alu_op = ILT;
                    3'b011: dec.alu_op = ILTU;
                    3'b100: dec.alu_op = IXOR;
                    3'b110: dec.alu_op = IOR;
                    3'b111: dec.alu_op = IAND;
                    3'b001: begin
                        dec.alu_op   = IPAS;
                        dec.is_shift = 1'b1;
                        kind         = IMM_SH;
                        legal        = (f7 == 7'b0000000);
                    end
                    default: begin
                        dec.alu_op   = IPAS;
                        dec.is_shift = 1'b1;
                        kind         = IMM_SH;
                        legal        = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    end
                endcase
            end
            OPC_OP: begin
                we    = 1'b1;
                legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                case (f3)
                    3'b000:  dec.alu_op = f7[5] ? ISUB : IADD;
                    3'b010:  dec.alu_op = ILT;
                    3'b011:  dec.alu_op = ILTU;
                    3'b100:  dec.alu_op = IXOR;
                    3'b110:  dec.alu_op = IOR;
                    3'b111:  dec.alu_op = IAND;
                    default: begin
                        dec.alu_op   = IPAS;
                        dec.is_shift = 1'b1;
                    end
                endcase
            end
            default: legal = 1'b0;
        endcase

        if (instr[1:0] != 2'b11)
            legal = 1'b0;

        // Illegal words still travel downstream with a neutral payload so the trap stays precise.
        if (!legal) begin
            dec           = '0;
            dec.rs1       = instr[19:15];
            dec.rs2       = instr[24:20];
            dec.rd        = instr[11:7];
            dec.funct3    = f3;
            dec.alu_op    = IADD;
            dec.illegal   = 1'b1;
            kind          = IMM_NONE;
            we            = 1'b0;
        end

        dec.imm   = build_imm(kind, instr);
        dec.rd_we = we && (instr[11:7] != 5'd0);
    end
endmodule

// File: rtl/id_stage.sv
// Decode stage: id_decode feeding a two-entry skid buffer (M drives outputs, S catches overflow).
module id_stage
    import id_stage_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC_TAG = '0
) (
    input logic       clk,
    input logic       reset,
    input logic       flush,
    id_stage_if.slave bus
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        decoded_t        dec;
    } entry_t;

    decoded_t dec;
    entry_t   incoming;
    entry_t   m;
    entry_t   s;
    logic     m_valid;
    logic     s_valid;
    logic     xfer;
    logic     m_free;

    id_decode u_decode (
        .instr (bus.in_instr),
        .dec   (dec)
    );

    assign incoming = {bus.in_pc, dec};

    // in_ready is the inverse of a flop, so it carries no combinational path from out_ready.
    assign bus.in_ready = ~s_valid;
    assign xfer         = bus.in_valid & ~s_valid;
    assign m_free       = ~m_valid | bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m       <= '0;
            s       <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (m_free) begin
            if (s_valid) begin
                m       <= s;
                m_valid <= 1'b1;
                s_valid <= xfer;
                if (xfer)
                    s <= incoming;
            end else begin
                m_valid <= xfer;
                if (xfer)
                    m <= incoming;
            end
        end else if (xfer) begin
            s       <= incoming;
            s_valid <= 1'b1;
        end
    end

    assign bus.out_valid     = m_valid;
    assign bus.out_pc        = m_valid ? m.pc : RESET_PC_TAG;
    assign bus.out_alu_op    = m.dec.alu_op;
    assign bus.out_rs1       = m.dec.rs1;
    assign bus.out_rs2       = m.dec.rs2;
    assign bus.out_rd        = m.dec.rd;
    assign bus.out_imm       = XLEN'(signed'(m.dec.imm));
    assign bus.out_a_sel     = m.dec.a_sel;
    assign bus.out_b_sel     = m.dec.b_sel;
    assign bus.out_rd_we     = m.dec.rd_we;
    assign bus.out_is_branch = m.dec.is_branch;
    assign bus.out_is_jump   = m.dec.is_jump;
    assign bus.out_is_load   = m.dec.is_load;
    assign bus.out_is_store  = m.dec.is_store;
    assign bus.out_is_shift  = m.dec.is_shift;
    assign bus.out_funct3    = m.dec.funct3;
    assign bus.out_illegal   = m.dec.illegal;
endmodule

// File: tb/tb_id_stage.sv
// Directed and random stimulus for id_stage against a 2-deep FIFO reference with its own RV32I decoder.
module tb_id_stage;
    import id_stage_pkg::*;

    localparam logic [31:0] TAG = 32'hDEAD_0000;

    typedef struct packed {
        logic [4:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        a_sel;
        logic        b_sel;
        logic        we;
        logic        br;
        logic        jmp;
        logic        ld;
        logic        st;
        logic        sh;
        logic [2:0]  f3;
        logic        ill;
    } ref_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [95:0] q[$];

    logic [4:0] alu_tab [8] = '{IADD, IPAS, ILT, ILTU, IXOR, IPAS, IOR, IAND};
    logic [4:0] br_tab  [8] = '{IEQ, INE, IADD, IADD, ILT, IGE, ILTU, IGEU};
    logic [6:0] opc_tab [9] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                                OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP};

    id_stage_if #(.XLEN(32)) bus ();

    id_stage #(.XLEN(32), .RESET_PC_TAG(TAG)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imm_i(input logic [31:0] i);
        return 32'($signed(i) >>> 20);
    endfunction
    function automatic logic [31:0] imm_s(input logic [31:0] i);
        return (32'($signed(i) >>> 25) << 5) | 32'(i[11:7]);
    endfunction
    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return (32'($signed(i) >>> 31) << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
    endfunction
    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return (32'($signed(i) >>> 31) << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
    endfunction

    function automatic ref_t ref_decode(input logic [31:0] i);
        ref_t       e;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         ok;
        bit         wr;
        f3 = i[14:12];
        f7 = i[31:25];
        ok = 1;
        wr = 0;
        e = '0;
        e.op = IADD;
        case (i[6:0])
            OPC_LUI:    begin e.op = IPAS; e.b_sel = 1; e.imm = i & 32'hFFFF_F000; wr = 1; end
            OPC_AUIPC:  begin e.a_sel = 1; e.b_sel = 1; e.imm = i & 32'hFFFF_F000; wr = 1; end
            OPC_JAL:    begin e.a_sel = 1; e.b_sel = 1; e.jmp = 1; e.imm = imm_j(i); wr = 1; end
            OPC_JALR:   begin e.b_sel = 1; e.jmp = 1; e.imm = imm_i(i); wr = 1; end
            OPC_BRANCH: begin e.br = 1; e.imm = imm_b(i); e.op = br_tab[f3]; ok = (f3 != 2 && f3 != 3); end
            OPC_LOAD:   begin e.b_sel = 1; e.ld = 1; e.imm = imm_i(i); wr = 1; end
            OPC_STORE:  begin e.b_sel = 1; e.st = 1; e.imm = imm_s(i); end
            OPC_OPIMM: begin
                wr = 1;
                e.b_sel = 1;
                if (f3 == 1 || f3 == 5) begin
                    e.sh = 1;
                    e.op = IPAS;
                    e.imm = 32'(i[24:20]);
                    ok = (f7 == 0) || (f3 == 5 && f7 == 7'h20);
                end else begin
                    e.op = alu_tab[f3];
                    e.imm = imm_i(i);
                end
            end
            OPC_OP: begin
                wr = 1;
                ok = (f7 == 0) || (f7 == 7'h20);
                if (f3 == 1 || f3 == 5) begin e.sh = 1; e.op = IPAS; end
                else if (f3 == 0 && f7 == 7'h20) e.op = ISUB;
                else e.op = alu_tab[f3];
            end
            default: ok = 0;
        endcase
        if (!ok) begin
            e = '0;
            e.op = IADD;
            e.ill = 1;
            wr = 0;
        end
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        e.rd  = i[11:7];
        e.f3  = f3;
        e.we  = wr && (i[11:7] != 0);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] f7;
        int unsigned k;
        int unsigned r;
        k = $urandom_range(0, 10);
        if (k >= 9)
            return $urandom();
        r = $urandom_range(0, 3);
        f7 = (r == 0) ? 7'h00 : (r == 1) ? 7'h20 : 7'($urandom());
        return {f7, 5'($urandom()), 5'($urandom()), 3'($urandom()), 5'($urandom()), opc_tab[k]};
    endfunction

    function automatic logic [95:0] observed();
        return {bus.out_pc, bus.out_alu_op, bus.out_rs1, bus.out_rs2, bus.out_rd, bus.out_imm,
                bus.out_a_sel, bus.out_b_sel, bus.out_rd_we, bus.out_is_branch, bus.out_is_jump,
                bus.out_is_load, bus.out_is_store, bus.out_is_shift, bus.out_funct3, bus.out_illegal};
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("in_ready", 96'(bus.in_ready), 96'(q.size() < 2));
        chk("out_valid", 96'(bus.out_valid), 96'(q.size() != 0));
        if (q.size() != 0)
            chk("payload", observed(), q[0]);
    endtask

    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic fl);
        bit acc;
        bit con;
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = ins;
        bus.out_ready = ordy;
        flush         = fl;
        @(posedge clk);
        acc = v && (q.size() < 2);
        con = ordy && (q.size() != 0);
        if (fl) begin
            q.delete();
        end else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back({pc, ref_decode(ins)});
        end
        #1;
        check_state();
    endtask

    initial begin
        logic [31:0] pc;
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b0;

        #1;
        chk("reset_state", observed(), {TAG, 64'd0});
        chk("reset_in_ready", 96'(bus.in_ready), 96'd1);
        chk("reset_out_valid", 96'(bus.out_valid), 96'd0);
        @(negedge clk);
        reset = 1'b0;

        cycle(1, 32'h100, 32'h00500093, 1, 0);
        chk("addi_valid", 96'(bus.out_valid), 96'd1);
        chk("addi_op", 96'(bus.out_alu_op), 96'(IADD));
        chk("addi_rd", 96'(bus.out_rd), 96'd1);
        chk("addi_rs1", 96'(bus.out_rs1), 96'd0);
        chk("addi_imm", 96'(bus.out_imm), 96'd5);
        chk("addi_bsel", 96'(bus.out_b_sel), 96'd1);
        chk("addi_we", 96'(bus.out_rd_we), 96'd1);

        cycle(1, 32'h104, 32'h402081B3, 1, 0);
        chk("sub_op", 96'(bus.out_alu_op), 96'(ISUB));
        chk("sub_regs", 96'({bus.out_rs1, bus.out_rs2, bus.out_rd}), 96'({5'd1, 5'd2, 5'd3}));
        chk("sub_bsel_ill", 96'({bus.out_b_sel, bus.out_illegal}), 96'd0);

        cycle(1, 32'h108, 32'h00208463, 1, 0);
        chk("beq_op", 96'(bus.out_alu_op), 96'(IEQ));
        chk("beq_imm", 96'(bus.out_imm), 96'd8);
        chk("beq_flags", 96'({bus.out_is_branch, bus.out_rd_we}), 96'b10);

        cycle(1, 32'h10C, 32'h123452B7, 1, 0);
        chk("lui_op", 96'(bus.out_alu_op), 96'(IPAS));
        chk("lui_imm", 96'(bus.out_imm), 96'h12345000);
        chk("lui_rd", 96'(bus.out_rd), 96'd5);

        cycle(1, 32'h110, 32'hFFFFFFFF, 1, 0);
        chk("ill_flags", 96'({bus.out_illegal, bus.out_rd_we}), 96'b10);
        cycle(0, 32'h0, 32'h0, 1, 0);

        // Back-pressure: third instruction must wait for the skid entry to drain.
        cycle(1, 32'h200, 32'h00100113, 0, 0);
        cycle(1, 32'h204, 32'h00200193, 0, 0);
        chk("full_in_ready", 96'(bus.in_ready), 96'd0);
        cycle(1, 32'h208, 32'h00300213, 0, 0);
        cycle(1, 32'h208, 32'h00300213, 1, 0);
        cycle(1, 32'h208, 32'h00300213, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 32'h0, 32'h0, 1, 0);
        chk("drained", 96'(bus.out_valid), 96'd0);

        // Flush with two held entries, then with one entry and an accepted input.
        cycle(1, 32'h300, 32'h00100113, 0, 0);
        cycle(1, 32'h304, 32'h00200193, 0, 0);
        cycle(1, 32'h308, 32'h00300213, 0, 1);
        chk("flush_valid", 96'(bus.out_valid), 96'd0);
        chk("flush_ready", 96'(bus.in_ready), 96'd1);
        cycle(1, 32'h30C, 32'h00400293, 0, 0);
        cycle(1, 32'h310, 32'h00500313, 1, 1);
        cycle(0, 32'h0, 32'h0, 1, 0);
        chk("flush_discard", 96'(bus.out_valid), 96'd0);

        pc = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), pc, rand_instr(),
                  1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
            pc += 4;
        end

        // Asynchronous reset in the middle of a cycle with entries buffered.
        cycle(1, 32'h500, 32'h00700393, 0, 0);
        cycle(1, 32'h504, 32'hFE010113, 0, 0);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset_out", observed(), {TAG, 64'd0});
        chk("async_reset_valid", 96'(bus.out_valid), 96'd0);
        chk("async_reset_ready", 96'(bus.in_ready), 96'd1);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'($urandom_range(0, 1)), pc, rand_instr(), 1'($urandom_range(0, 1)), 0);
            pc += 4;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
